video_timing_gen: RTL
=====================

Name: video_timing_gen

Overview:
Upstream video source stage for the DVI/HDMI TMDS encoder. It generates raster timing (hsync, vsync, data enable) from programmable porch and sync parameters and issues a pixel request with x/y coordinates a fixed number of cycles ahead of display. It captures the returned RGB and presents timing plus pixel data, cycle-aligned, on video_* outputs that connect directly to the encoder's hsync/vsync/de/din inputs. It runs in the pixel clock domain (74.25 MHz for 720p60 defaults).

Parameters:
H_ACTIVE, 1280, active pixels per line
H_FP, 110, horizontal front porch (clocks)
H_SYNC, 40, hsync width (clocks)
H_BP, 220, horizontal back porch (clocks)
V_ACTIVE, 720, active lines per frame
V_FP, 5, vertical front porch (lines)
V_SYNC, 5, vsync width (lines)
V_BP, 20, vertical back porch (lines)
HS_POL, 1, hsync active level
VS_POL, 1, vsync active level
REQ_LEAD, 2, cycles from pix_req to pixel data on pix_r/g/b; legal range 1..8

Ports:
clk  in  1  pixel clock
rst_n  in  1  reset, asynchronous, active-low
en  in  1  run enable; low holds the raster at origin
pix_req  out  1  pixel fetch request (active region)
pix_x  out  12  requested column, 0..H_ACTIVE-1
pix_y  out  12  requested line, 0..V_ACTIVE-1
frame_start  out  1  one-cycle pulse coincident with pix_req for (0,0)
pix_r  in  8  red for the request issued REQ_LEAD cycles earlier
pix_g  in  8  green, same timing
pix_b  in  8  blue, same timing
video_hs  out  1  hsync to encoder
video_vs  out  1  vsync to encoder
video_de  out  1  data enable to encoder
video_r  out  8  red to encoder
video_g  out  8  green to encoder
video_b  out  8  blue to encoder

Behaviour:
- Reset (async, rst_n low): h_cnt=0, v_cnt=0, pix_req=0, pix_x=0, pix_y=0, frame_start=0, video_hs=~HS_POL, video_vs=~VS_POL, video_de=0, video_r/g/b=0, delay line cleared to inactive.
- Counters: 12-bit h_cnt runs 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP). On wrap, v_cnt increments and runs 0..V_TOTAL-1, then wraps to 0. H_TOTAL and V_TOTAL must each be ≤ 4096.
- Raster order per line: active region, front porch, sync, back porch. Active region is h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- Stage 0 (registered decode of counters):
  - pix_req = active.
  - pix_x = h_cnt and pix_y = v_cnt while active; both hold their last value otherwise.
  - frame_start = (h_cnt==0 && v_cnt==0 && en).
  - hs_i = (H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC).
  - vs_i = (V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC). vs_i spans whole lines and changes only when h_cnt=0.
- Delay line: {de_i, hs_i, vs_i} shift REQ_LEAD stages.
- Output register: video_de/hs/vs take the delayed values, with polarity applied to hs and vs.
  - video_r/g/b = pix_r/g/b when the delayed de_i=1, else 0.
  - Total latency from pix_req to video_de is REQ_LEAD+1 cycles. Timing and data stay exactly aligned.
- en low: on the next edge, counters return to (0,0) and stage 0 outputs go inactive (pix_req=0, hs_i/vs_i inactive). The delay line keeps shifting, so video outputs drain to the blank/inactive level within REQ_LEAD+1 cycles.
- en rising: the first enabled cycle is h=0, v=0. pix_req and frame_start are asserted that cycle. No partial frame is emitted.
- en toggled mid-frame: the raster aborts and restarts at origin on re-enable.
- pix_* inputs are ignored when the delayed de_i=0.

Optional Feature:
- Macro VTG_PATTERN_EN. When defined, adds input port pat_sel (1 bit).
  - With pat_sel=1: pix_req is forced to 0, pix_x/pix_y/frame_start are unchanged, and video_r/g/b show 8 equal-width vertical colour bars from the delayed x. Bar index = x*8/H_ACTIVE. Order: white, yellow, cyan, green, magenta, red, blue, black (components 8'hFF/8'h00).
  - pat_sel is sampled only at frame_start, so a change takes effect on the next frame.
- When not defined: no pat_sel port and no bar logic; behaviour is exactly as above.

Test Plan:
Bench parameters: H 8/2/2/2 (H_TOTAL 14), V 4/1/1/1 (V_TOTAL 7), REQ_LEAD 2, POL 1.
- Reset with en=0 → video_hs=0, video_vs=0, video_de=0, rgb=0, pix_req=0 held for 50 cycles.
- en=1 at cycle T → pix_req high T..T+7 with pix_x 0..7 then low for 6 cycles; frame_start high only at T; frame period 98 cycles; 4 request lines per frame.
- Bench returns pix_r=pix_x 2 cycles after request → video_de high T+3..T+10 with video_r 0..7; video_r=0 at T+11..T+16.
- Sync → video_hs high at T+13, T+14 (h_cnt 10,11 + 3) each line; video_vs high for exactly 14 cycles starting T+3+5*14; de never high while vs high.
- en dropped when pix_x=3 → pix_req=0 next cycle, video_de low within 3 cycles; re-enable gives frame_start with pix_x=0, pix_y=0.
- VTG_PATTERN_EN, pat_sel=1 before frame_start → pix_req stays 0; video rgb over the 8 active pixels = FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing generator with look-ahead pixel requests and aligned RGB capture for the TMDS encoder.
// Define VTG_PATTERN_EN to add the pat_sel input and the built-in 8-bar colour pattern.
module video_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int REQ_LEAD = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
`ifdef VTG_PATTERN_EN
    input  logic        pat_sel,
`endif
    output logic        pix_req,
    output logic [11:0] pix_x,
    output logic [11:0] pix_y,
    output logic        frame_start,
    input  logic [7:0]  pix_r,
    input  logic [7:0]  pix_g,
    input  logic [7:0]  pix_b,
    output logic        video_hs,
    output logic        video_vs,
    output logic        video_de,
    output logic [7:0]  video_r,
    output logic [7:0]  video_g,
    output logic [7:0]  video_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 13-bit constants so a 4096-wide raster still compares correctly against 12-bit counters
    localparam logic [12:0] C_H_ACT  = 13'(H_ACTIVE);
    localparam logic [12:0] C_HS_BEG = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] C_HS_END = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] C_H_LAST = 13'(H_TOTAL - 1);
    localparam logic [12:0] C_V_ACT  = 13'(V_ACTIVE);
    localparam logic [12:0] C_VS_BEG = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] C_VS_END = 13'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [12:0] C_V_LAST = 13'(V_TOTAL - 1);

    logic [11:0] r_h_cnt;
    logic [11:0] r_v_cnt;
    logic [12:0] w_h;
    logic [12:0] w_v;
    logic        w_h_wrap;
    logic        w_v_wrap;
    logic        w_active;
    logic        w_hs_win;
    logic        w_vs_win;
    logic        w_fs;
    logic        w_de_nxt;
    logic        w_req_nxt;

    logic        r_de_i;
    logic        r_hs_i;
    logic        r_vs_i;
    logic        r_pix_req;
    logic [11:0] r_pix_x;
    logic [11:0] r_pix_y;
    logic        r_frame_start;

    logic        r_dly_de [REQ_LEAD];
    logic        r_dly_hs [REQ_LEAD];
    logic        r_dly_vs [REQ_LEAD];
    logic        w_de_d;

    logic        r_video_hs;
    logic        r_video_vs;
    logic        r_video_de;
    logic [23:0] r_video_rgb;
    logic [23:0] w_rgb;

    assign w_h      = {1'b0, r_h_cnt};
    assign w_v      = {1'b0, r_v_cnt};
    assign w_h_wrap = (w_h == C_H_LAST);
    assign w_v_wrap = (w_v == C_V_LAST);
    assign w_active = (w_h < C_H_ACT) && (w_v < C_V_ACT);
    assign w_hs_win = (w_h >= C_HS_BEG) && (w_h < C_HS_END);
    assign w_vs_win = (w_v >= C_VS_BEG) && (w_v < C_VS_END);
    assign w_fs     = en && (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);
    assign w_de_nxt = en && w_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= 12'd0;
            r_v_cnt <= 12'd0;
        end else if (!en) begin
            r_h_cnt <= 12'd0;
            r_v_cnt <= 12'd0;
        end else if (w_h_wrap) begin
            r_h_cnt <= 12'd0;
            r_v_cnt <= w_v_wrap ? 12'd0 : r_v_cnt + 12'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 12'd1;
        end
    end

`ifdef VTG_PATTERN_EN
    // Pattern choice is frozen per frame: only the origin cycle may change it
    logic r_pat;
    logic w_pat_nxt;

    assign w_pat_nxt = w_fs ? pat_sel : r_pat;
    assign w_req_nxt = w_de_nxt && !w_pat_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pat <= 1'b0;
        end else begin
            r_pat <= w_pat_nxt;
        end
    end
`else
    assign w_req_nxt = w_de_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_de_i        <= 1'b0;
            r_hs_i        <= 1'b0;
            r_vs_i        <= 1'b0;
            r_pix_req     <= 1'b0;
            r_pix_x       <= 12'd0;
            r_pix_y       <= 12'd0;
            r_frame_start <= 1'b0;
        end else begin
            r_de_i        <= w_de_nxt;
            r_hs_i        <= en && w_hs_win;
            r_vs_i        <= en && w_vs_win;
            r_pix_req     <= w_req_nxt;
            r_frame_start <= w_fs;
            if (w_de_nxt) begin
                r_pix_x <= r_h_cnt;
                r_pix_y <= r_v_cnt;
            end
        end
    end

`ifdef VTG_PATTERN_EN
    logic [11:0] r_dly_x   [REQ_LEAD];
    logic        r_dly_pat [REQ_LEAD];
`endif

    // Delay line matches the fetch latency; it never stalls so disabling drains it cleanly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REQ_LEAD; i++) begin
                r_dly_de[i] <= 1'b0;
                r_dly_hs[i] <= 1'b0;
                r_dly_vs[i] <= 1'b0;
`ifdef VTG_PATTERN_EN
                r_dly_x[i]   <= 12'd0;
                r_dly_pat[i] <= 1'b0;
`endif
            end
        end else begin
            r_dly_de[0] <= r_de_i;
            r_dly_hs[0] <= r_hs_i;
            r_dly_vs[0] <= r_vs_i;
`ifdef VTG_PATTERN_EN
            r_dly_x[0]   <= r_pix_x;
            r_dly_pat[0] <= r_pat;
`endif
            for (int i = 1; i < REQ_LEAD; i++) begin
                r_dly_de[i] <= r_dly_de[i-1];
                r_dly_hs[i] <= r_dly_hs[i-1];
                r_dly_vs[i] <= r_dly_vs[i-1];
`ifdef VTG_PATTERN_EN
                r_dly_x[i]   <= r_dly_x[i-1];
                r_dly_pat[i] <= r_dly_pat[i-1];
`endif
            end
        end
    end

    assign w_de_d = r_dly_de[REQ_LEAD-1];

`ifdef VTG_PATTERN_EN
    logic [2:0]  w_bar_idx;
    logic [11:0] w_x_d;
    logic        w_pat_d;

    assign w_x_d   = r_dly_x[REQ_LEAD-1];
    assign w_pat_d = r_dly_pat[REQ_LEAD-1];

    // bar = floor(x*8/H_ACTIVE) evaluated as threshold compares, no divider
    always_comb begin
        w_bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if ({1'b0, w_x_d, 3'b000} >= 16'(k * H_ACTIVE)) begin
                w_bar_idx = 3'(k);
            end
        end
    end
`endif

    always_comb begin
        w_rgb = 24'd0;
        if (w_de_d) begin
            w_rgb = {pix_r, pix_g, pix_b};
        end
`ifdef VTG_PATTERN_EN
        if (w_de_d && w_pat_d) begin
            w_rgb = {{8{~w_bar_idx[1]}}, {8{~w_bar_idx[2]}}, {8{~w_bar_idx[0]}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_video_hs  <= ~HS_POL;
            r_video_vs  <= ~VS_POL;
            r_video_de  <= 1'b0;
            r_video_rgb <= 24'd0;
        end else begin
            r_video_hs  <= r_dly_hs[REQ_LEAD-1] ? HS_POL : ~HS_POL;
            r_video_vs  <= r_dly_vs[REQ_LEAD-1] ? VS_POL : ~VS_POL;
            r_video_de  <= w_de_d;
            r_video_rgb <= w_rgb;
        end
    end

    assign pix_req     = r_pix_req;
    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;
    assign frame_start = r_frame_start;
    assign video_hs    = r_video_hs;
    assign video_vs    = r_video_vs;
    assign video_de    = r_video_de;
    assign video_r     = r_video_rgb[23:16];
    assign video_g     = r_video_rgb[15:8];
    assign video_b     = r_video_rgb[7:0];

endmodule
